// File: rtl/instruction_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader_if
// Brief    : Byte-stream input and instruction-memory write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic                  cpu_hold;
    logic                  done;

    // Stream source / load controller side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
    );
endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Brief    : Packs a byte stream (high byte first) into 16-bit words and
//            writes them to instruction memory from address 0, stalling the
//            core for the duration of the load.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader #(
    parameter int NUM_WORDS  = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instruction_loader_if.slave bus
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_high  = 3'd1;
    localparam logic [2:0] c_low   = 3'd2;
    localparam logic [2:0] c_write = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [7:0]            r_hi;
    logic [7:0]            r_lo;
    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_begin;

    // in_ready is a pure state decode, so the transfer term never loops back
    assign w_xfer  = bus.in_valid & w_in_ready;
    assign w_begin = bus.start & ((r_state == c_idle) | (r_state == c_done));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_begin) w_next_state = c_high;
            c_high:  if (w_xfer)  w_next_state = c_low;
            c_low:   if (w_xfer)  w_next_state = c_write;
            c_write: w_next_state = (r_addr_cnt == c_last_addr) ? c_done : c_high;
            c_done:  if (w_begin) w_next_state = c_high;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_in_ready   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.cpu_hold = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            c_high: begin
                w_in_ready   = 1'b1;
                bus.cpu_hold = 1'b1;
            end
            c_low: begin
                w_in_ready   = 1'b1;
                bus.cpu_hold = 1'b1;
            end
            c_write: begin
                bus.mem_we   = 1'b1;
                bus.cpu_hold = 1'b1;
            end
            c_done:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Word assembly and write-address counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_cnt <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            if (w_begin) begin
                r_addr_cnt <= '0;
            end else if ((r_state == c_write) && (r_addr_cnt != c_last_addr)) begin
                r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
            end
            if ((r_state == c_high) && w_xfer) begin
                r_hi <= bus.in_data;
            end
            if ((r_state == c_low) && w_xfer) begin
                r_lo <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_addr  = r_addr_cnt;
    assign bus.mem_wdata = {r_hi, r_lo};

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
# instruction_loader

Loads a program into the writable instruction memory from an 8-bit byte stream. It assembles pairs of bytes into 16-bit instruction words, high byte first, and writes them to consecutive addresses starting at 0. While a load is in progress it holds the processor core stalled. It sits on the write port of instruction memory, opposite the core's fetch path, which reads instruction words by address.

## Interface
Parameters:
- NUM_WORDS, 16, number of instruction words per load; legal range 1..64.
- ADDR_WIDTH, 6, width of mem_addr; matches the instruction-memory read address width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  program byte; each word arrives as high byte, then low byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  16  write data, {high_byte, low_byte}.
- cpu_hold  output  1  stalls the core while a load is in progress.
- done  output  1  the most recent load completed all NUM_WORDS words.

## Operation
- States: IDLE, HIGH, LOW, WRITE, DONE. The state register is binary encoded.
- Byte transfer: a byte is transferred on a rising edge where in_valid=1 and in_ready=1.
- in_ready is a decode of the state register only, with no combinational path from in_valid: in_ready=1 in HIGH and LOW, 0 elsewhere.
- IDLE: start=1 → HIGH, addr_cnt←0, cpu_hold←1, done←0.
- HIGH: on a transfer, hi_reg←in_data → LOW. Otherwise stay in HIGH.
- LOW: on a transfer, lo_reg←in_data → WRITE. Otherwise stay in LOW.
- WRITE: mem_we=1, mem_addr=addr_cnt, mem_wdata={hi_reg,lo_reg} for exactly one cycle.
  - If addr_cnt==NUM_WORDS-1 → DONE, with done←1 and cpu_hold←0.
  - Otherwise addr_cnt←addr_cnt+1 → HIGH.
- DONE: done is held at 1 and cpu_hold at 0. start=1 → HIGH, with the same actions as from IDLE (reload).
- start is ignored in HIGH, LOW and WRITE. It does not restart, reset the counter or stall the load.
- mem_addr always equals addr_cnt. It is zero-extended only if NUM_WORDS < 2^ADDR_WIDTH, and it never wraps within a load.
- mem_wdata is valid only while mem_we=1. Outside that cycle it reflects hi_reg/lo_reg and carries no meaning.
- Excess bytes offered after the last word are never accepted; in_ready stays 0 in WRITE and DONE.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, done 0.
- Reset mid-load: the next cycle is IDLE with all outputs at their reset values.
  - A partially assembled word is discarded.
  - Words already written stay in memory. The loader does not clear them.
  - done stays 0 until a full load completes.

## Timing
- Byte-to-write latency: the low byte accepted at edge N produces mem_we=1 during cycle N+1. The write commits at edge N+2.
- Minimum time per word is 3 cycles (HIGH, LOW, WRITE), so a full load takes at least 3·NUM_WORDS cycles after start.
- done and cpu_hold change at the edge that ends the last WRITE cycle. The core is released exactly one cycle after the final write is issued.
- cpu_hold rises at the edge that samples start, which is the same edge on which the state enters HIGH.
- in_valid gaps of any length in HIGH or LOW simply hold the state; they impose no timeout.
- If reset and start are both high at the same edge, reset wins.

## Test plan
- Back-to-back load, NUM_WORDS=16, bytes 0x20,0x10,0xE2,0x02,…:
  - exactly 16 mem_we pulses at addresses 0..15.
  - word 0 = 0x2010, word 1 = 0xE202.
  - each pulse comes 1 cycle after its low byte.
  - done=1 and cpu_hold=0 at cycle 48 after start.
- Random in_valid gaps (0–5 cycles) on the same stream:
  - identical write sequence and data.
  - in_ready never 1 in WRITE.
  - no byte dropped or duplicated.
- start pulsed during the load while in LOW at word 3:
  - ignored; addr_cnt continues at 3.
  - still exactly 16 writes.
- reset asserted while in HIGH at word 7, then a new start and full stream:
  - all outputs 0 the cycle after reset.
  - reload writes addresses 0..15 from word 0.
- Reload from DONE:
  - start → done drops to 0 and cpu_hold rises to 1 the next cycle.
  - second stream overwrites addresses 0..15.
- NUM_WORDS=1 with bytes 0x30,0x00:
  - one write of 0x3000 to address 0.
  - DONE 3 cycles after start.
  - further bytes are not accepted (in_ready=0).
